// File: rtl/smachine_prog_loader_if.sv
// rtl/smachine_prog_loader_if.sv - byte-stream and instruction-memory write bus for the program loader
// Purpose: groups the loader's byte-stream handshake and its instruction-memory write port.
// Signals:
//   rx_data  [7:0]        incoming byte
//   rx_valid              rx_data is valid
//   rx_ready              loader can accept a byte
//   wr_en                 instruction-memory write strobe
//   wr_addr  [ADDR_W-1:0] write address
//   wr_data  [DATA_W-1:0] write data
// Modports: master = loader side, slave = byte source / memory side.
interface smachine_prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/smachine_prog_loader.sv
// rtl/smachine_prog_loader.sv - S-Machine program loader: byte stream to instruction memory, gates CPU enable
// Purpose: accepts a length byte N (0 = 256), then N big-endian 16-bit words, and writes
// them to instruction memory from address 0; releases cpu_enable once the image is in.
// Optional feature macro: SMACHINE_LOADER_CHECKSUM_EN (trailing XOR checksum byte, ERR state).
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_start          one-cycle pulse that begins a load (ignored while busy)
//   bus (master)     rx_data/rx_valid/rx_ready byte stream, wr_en/wr_addr/wr_data write port
//   o_cpu_enable     CPU enable, high from the second DONE cycle on
//   o_busy           load in progress
//   o_done           image loaded
//   o_err            checksum mismatch (always 0 without the checksum feature)
module smachine_prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  smachine_prog_loader_if.master bus,
  output logic                  o_cpu_enable,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
`ifdef SMACHINE_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [7:0]        r_len;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_hi;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_cpu_en;
  logic              w_busy;
  logic              w_acc;
  logic              w_last;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_n_full;
`ifdef SMACHINE_LOADER_CHECKSUM_EN
  logic [7:0]        r_sum;
`endif

  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      S_LEN, S_HI, S_LO: w_busy = 1'b1;
`ifdef SMACHINE_LOADER_CHECKSUM_EN
      S_CHK:             w_busy = 1'b1;
`endif
      default:           w_busy = 1'b0;
    endcase
  end

  assign w_acc     = bus.rx_valid && w_busy;
  // The counter is one bit wider than the address so N=0 can mean 256 words.
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_n_full  = (r_len == 8'd0) ? CNT_W'(256) : CNT_W'(r_len);
  assign w_last    = (w_cnt_inc == w_n_full);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nx = S_LEN;
      S_LEN:  if (w_acc) w_state_nx = S_HI;
      S_HI:   if (w_acc) w_state_nx = S_LO;
      S_LO: begin
        if (w_acc) begin
`ifdef SMACHINE_LOADER_CHECKSUM_EN
          w_state_nx = w_last ? S_CHK : S_HI;
`else
          w_state_nx = w_last ? S_DONE : S_HI;
`endif
        end
      end
`ifdef SMACHINE_LOADER_CHECKSUM_EN
      S_CHK:  if (w_acc) w_state_nx = (bus.rx_data == r_sum) ? S_DONE : S_ERR;
`endif
      S_DONE, S_ERR: if (i_start) w_state_nx = S_LEN;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_cpu_en  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      // Low on the first DONE cycle (the final write is still on the bus), and
      // dropped on the same edge that leaves DONE.
      r_cpu_en <= (r_state == S_DONE) && (w_state_nx == S_DONE);
      r_wr_en  <= 1'b0;
      if (w_acc) begin
        case (r_state)
          S_LEN: begin
            r_len <= bus.rx_data;
            r_cnt <= '0;
          end
          S_HI: r_hi <= bus.rx_data;
          S_LO: begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_cnt[ADDR_W-1:0];
            r_wr_data <= DATA_W'({r_hi, bus.rx_data});
            r_cnt     <= w_cnt_inc;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SMACHINE_LOADER_CHECKSUM_EN
  // Running XOR seeded by the length byte; the CHK byte itself is folded in too,
  // which is harmless because the comparison uses the pre-update value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum <= '0;
    end else if (w_acc) begin
      r_sum <= (r_state == S_LEN) ? bus.rx_data : (r_sum ^ bus.rx_data);
    end
  end
  assign o_err = (r_state == S_ERR);
`else
  assign o_err = 1'b0;
`endif

  assign bus.rx_ready = w_busy;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign o_busy       = w_busy;
  assign o_done       = (r_state == S_DONE);
  assign o_cpu_enable = r_cpu_en;
endmodule

// File: tb/tb_smachine_prog_loader.sv
// tb/tb_smachine_prog_loader.sv - self-checking bench for smachine_prog_loader
module tb_smachine_prog_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cpu_enable, busy, done, err;

  smachine_prog_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  smachine_prog_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .bus          (bus),
    .o_cpu_enable (cpu_enable),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int gap_busy_bad = 0;
  logic [15:0] img [256];
  logic [7:0]  log_addr [$];
  logic [15:0] log_data [$];

  always @(negedge clk) begin
    if (bus.wr_en) begin
      log_addr.push_back(bus.wr_addr);
      log_data.push_back(bus.wr_data);
    end
  end

  typedef struct {
    string       name;
    logic [7:0]  len;
    int          gap;
    logic [15:0] w0, w1, w2;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) begin
      @(posedge clk); #1;
      if (!busy) gap_busy_bad++;
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'hEE;
  endtask

  // Sends a complete image from img[], then checks done/err/cpu_enable timing and the write log.
  task automatic load(input string pfx, input logic [7:0] n, input int gap, input bit bad,
                      input bit do_start, input bit mid_start);
    int nw;
    int mism;
    logic [7:0] sum;
    nw = (n == 8'd0) ? 256 : int'(n);
    log_addr.delete();
    log_data.delete();
    if (do_start) pulse_start();
    sum = n;
    send(n, gap);
    if (mid_start) begin
      pulse_start();
      check({pfx, "_start_ignored_busy"}, 32'(busy), 32'd1);
    end
    for (int i = 0; i < nw; i++) begin
      send(img[i][15:8], gap);
      send(img[i][7:0], gap);
      sum = sum ^ img[i][15:8] ^ img[i][7:0];
    end
`ifdef SMACHINE_LOADER_CHECKSUM_EN
    send(bad ? 8'h00 : sum, gap);
`endif
    check({pfx, "_done"}, 32'(done), 32'(!bad));
    check({pfx, "_err"}, 32'(err), 32'(bad));
    check({pfx, "_busy_off"}, 32'(busy), 32'd0);
    check({pfx, "_cpu_en_first"}, 32'(cpu_enable), 32'd0);
    @(posedge clk); #1;
    check({pfx, "_cpu_en_next"}, 32'(cpu_enable), 32'(!bad));
    check({pfx, "_wr_count"}, 32'(log_addr.size()), 32'(nw));
    mism = 0;
    for (int i = 0; i < nw && i < log_addr.size(); i++) begin
      if (log_addr[i] !== 8'(i) || log_data[i] !== img[i]) mism++;
    end
    check({pfx, "_wr_content"}, 32'(mism), 32'd0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({pfx, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    check({pfx, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    check({pfx, "_wr_data"}, 32'(bus.wr_data), 32'd0);
    check({pfx, "_cpu_enable"}, 32'(cpu_enable), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_err"}, 32'(err), 32'd0);
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{name: "basic",    len: 8'd2, gap: 0, w0: 16'h1234, w1: 16'hABCD, w2: 16'h0000};
    vecs[1] = '{name: "gaps",     len: 8'd2, gap: 3, w0: 16'h1234, w1: 16'hABCD, w2: 16'h0000};
    vecs[2] = '{name: "one_word", len: 8'd1, gap: 0, w0: 16'hBEEF, w1: 16'h0000, w2: 16'h0000};
    vecs[3] = '{name: "three",    len: 8'd3, gap: 1, w0: 16'h0001, w1: 16'h8000, w2: 16'hFFFF};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", 32'(bus.rx_ready), 32'd0);

    for (int v = 0; v < 4; v++) begin
      img[0] = vecs[v].w0;
      img[1] = vecs[v].w1;
      img[2] = vecs[v].w2;
      gap_busy_bad = 0;
      load(vecs[v].name, vecs[v].len, vecs[v].gap, 1'b0, 1'b1, 1'b0);
      check({vecs[v].name, "_busy_in_gaps"}, 32'(gap_busy_bad), 32'd0);
    end

    // Restart from DONE: enable drops on the start edge; a start while busy is ignored.
    check("restart_pre_cpu_en", 32'(cpu_enable), 32'd1);
    pulse_start();
    check("restart_cpu_en", 32'(cpu_enable), 32'd0);
    check("restart_done", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    img[0] = 16'hCAFE;
    img[1] = 16'h0102;
    load("restart", 8'd2, 0, 1'b0, 1'b0, 1'b1);

    // Full depth: N=0 means 256 words.
    for (int i = 0; i < 256; i++) img[i] = 16'(i * 16'h0101) ^ 16'h5A3C;
    load("full", 8'd0, 0, 1'b0, 1'b1, 1'b0);
    if (log_addr.size() >= 256) check("full_last_addr", 32'(log_addr[255]), 32'hFF);
    repeat (5) @(posedge clk);
    #1;
    check("full_no_extra_write", 32'(log_addr.size()), 32'd256);

    // Reset mid-load, after the high byte of word 1.
    pulse_start();
    send(8'h02, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'hAB, 0);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    img[0] = 16'h1234;
    img[1] = 16'hABCD;
    load("after_rst", 8'd2, 0, 1'b0, 1'b1, 1'b0);

`ifdef SMACHINE_LOADER_CHECKSUM_EN
    load("bad_chk", 8'd2, 0, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("bad_chk_cpu_en_stays", 32'(cpu_enable), 32'd0);
    load("good_after_err", 8'd2, 0, 1'b0, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
